// File: rtl/rv32i_exec_unit_if.sv
// Operand/result bundle between the forwarding stage and the RV32I execute
// datapath. The master drives operands and the instruction word; the slave
// (the execute unit) returns result, branch outcome and decoded immediate.
interface rv32i_exec_unit_if;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic [31:0] inst;
    logic [31:0] result;
    logic        take_b;
    logic [31:0] imm;

    modport master (
        output in_a,
        output in_b,
        output inst,
        input  result,
        input  take_b,
        input  imm
    );

    modport slave (
        input  in_a,
        input  in_b,
        input  inst,
        output result,
        output take_b,
        output imm
    );
endinterface

// File: rtl/rv32i_exec_unit.sv
// RV32I execute datapath: ALU, branch comparator and immediate decoder, all
// decoded from the raw instruction word.
//
// Build option: define EXEC_OUTREG_EN to add an output register stage
// (1-cycle latency, synchronous active-high reset clears all outputs).
// Without it the unit is purely combinational and clk/reset are unused.
module rv32i_exec_unit (
    input  logic                     clk,
    input  logic                     reset,
    rv32i_exec_unit_if.slave         bus
);

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    logic [6:0]  opcode_s;
    logic [2:0]  funct3_s;
    logic        alt_s;
    logic [4:0]  shamt_s;
    logic [31:0] sum_s;
    logic [31:0] diff_s;
    logic        lt_s;
    logic        ltu_s;
    logic        eq_s;
    logic [31:0] alu_s;
    logic        take_s;
    logic [31:0] imm_s;

    assign opcode_s = bus.inst[6:0];
    assign funct3_s = bus.inst[14:12];
    assign alt_s    = bus.inst[30];
    assign shamt_s  = bus.in_b[4:0];

    // Shared adder/subtractor and comparators used by both ALU and branch unit
    always_comb begin
        sum_s  = bus.in_a + bus.in_b;
        diff_s = bus.in_a - bus.in_b;
        lt_s   = ($signed(bus.in_a) < $signed(bus.in_b));
        ltu_s  = (bus.in_a < bus.in_b);
        eq_s   = (bus.in_a == bus.in_b);
    end

    // ALU: full operation set for OP/OP-IMM, plain add for every other opcode
    always_comb begin
        alu_s = sum_s;
        if ((opcode_s == OPC_OP) || (opcode_s == OPC_OPIMM)) begin
            case (funct3_s)
                3'b000: begin
                    // OP-IMM has no subtract; inst[30] there is immediate data
                    if ((opcode_s == OPC_OP) && alt_s) begin
                        alu_s = diff_s;
                    end else begin
                        alu_s = sum_s;
                    end
                end
                3'b001: alu_s = bus.in_a << shamt_s;
                3'b010: alu_s = {31'd0, lt_s};
                3'b011: alu_s = {31'd0, ltu_s};
                3'b100: alu_s = bus.in_a ^ bus.in_b;
                3'b101: begin
                    if (alt_s) begin
                        alu_s = $unsigned($signed(bus.in_a) >>> shamt_s);
                    end else begin
                        alu_s = bus.in_a >> shamt_s;
                    end
                end
                3'b110: alu_s = bus.in_a | bus.in_b;
                3'b111: alu_s = bus.in_a & bus.in_b;
                default: alu_s = sum_s;
            endcase
        end else begin
            alu_s = sum_s;
        end
    end

    // Branch comparator: only conditional branches can assert take_b
    always_comb begin
        take_s = 1'b0;
        if (opcode_s == OPC_BRANCH) begin
            case (funct3_s)
                3'b000:  take_s = eq_s;
                3'b001:  take_s = ~eq_s;
                3'b100:  take_s = lt_s;
                3'b101:  take_s = ~lt_s;
                3'b110:  take_s = ltu_s;
                3'b111:  take_s = ~ltu_s;
                default: take_s = 1'b0;
            endcase
        end else begin
            take_s = 1'b0;
        end
    end

    // Immediate decoder: format chosen by opcode, zero for formats without one
    always_comb begin
        imm_s = 32'd0;
        case (opcode_s)
            OPC_LOAD, OPC_OPIMM, OPC_JALR:
                imm_s = {{20{bus.inst[31]}}, bus.inst[31:20]};
            OPC_STORE:
                imm_s = {{20{bus.inst[31]}}, bus.inst[31:25], bus.inst[11:7]};
            OPC_BRANCH:
                imm_s = {{20{bus.inst[31]}}, bus.inst[7], bus.inst[30:25],
                         bus.inst[11:8], 1'b0};
            OPC_LUI, OPC_AUIPC:
                imm_s = {bus.inst[31:12], 12'd0};
            OPC_JAL:
                imm_s = {{12{bus.inst[31]}}, bus.inst[19:12], bus.inst[20],
                         bus.inst[30:21], 1'b0};
            default:
                imm_s = 32'd0;
        endcase
    end

`ifdef EXEC_OUTREG_EN
    logic [31:0] result_r;
    logic        take_b_r;
    logic [31:0] imm_r;

    // Output stage: capture datapath results; reset discards in-flight values
    always_ff @(posedge clk) begin
        if (reset) begin
            result_r <= 32'd0;
            take_b_r <= 1'b0;
            imm_r    <= 32'd0;
        end else begin
            result_r <= alu_s;
            take_b_r <= take_s;
            imm_r    <= imm_s;
        end
    end

    assign bus.result = result_r;
    assign bus.take_b = take_b_r;
    assign bus.imm    = imm_r;
`else
    // Clock and reset are kept on the port list for drop-in compatibility
    // with the registered build but have no function here.
    logic unused_clk_reset_s;
    assign unused_clk_reset_s = clk ^ reset;

    assign bus.result = alu_s;
    assign bus.take_b = take_s;
    assign bus.imm    = imm_s;
`endif

endmodule

// File: tb/tb_rv32i_exec_unit.sv
// Scoreboard bench for rv32i_exec_unit. The driver applies one vector per
// cycle on the falling edge and queues its expected outputs; an independent
// monitor samples just after each rising edge and compares. The same timing
// covers both the combinational and the registered build.
module tb_rv32i_exec_unit;

    typedef struct packed {
        logic [31:0] res;
        logic        tkb;
        logic [31:0] imm;
    } exp_t;

    logic clk;
    logic reset;
    logic vec_valid;
    int   n_checks;
    int   n_pass;

    exp_t  exp_q[$];
    string name_q[$];

    rv32i_exec_unit_if bus ();

    rv32i_exec_unit dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    // Free-running clock, 10 time-unit period
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check32(input string nm, input string fld,
                           input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) begin
            n_pass++;
        end else begin
            $display("FAIL %s.%s: got 0x%08h, expected 0x%08h", nm, fld, act, req);
        end
    endtask

    task automatic apply(input string nm, input logic rst,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] ins, input logic [31:0] e_res,
                         input logic e_tkb, input logic [31:0] e_imm);
        exp_t e;
        @(negedge clk);
        reset    = rst;
        bus.in_a = a;
        bus.in_b = b;
        bus.inst = ins;
        e.res = e_res;
        e.tkb = e_tkb;
        e.imm = e_imm;
        exp_q.push_back(e);
        name_q.push_back(nm);
        vec_valid = 1'b1;
    endtask

    // Monitor: one comparison set per presented vector, just after the edge
    initial begin
        exp_t  e;
        string nm;
        forever begin
            @(posedge clk);
            #1;
            if (vec_valid) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL scoreboard: output presented, expected-queue empty");
                end else begin
                    e  = exp_q.pop_front();
                    nm = name_q.pop_front();
                    check32(nm, "result", bus.result, e.res);
                    check32(nm, "take_b", {31'd0, bus.take_b}, {31'd0, e.tkb});
                    check32(nm, "imm", bus.imm, e.imm);
                end
            end
        end
    end

    // Driver: directed vectors with hand-computed expectations
    initial begin
        n_checks  = 0;
        n_pass    = 0;
        vec_valid = 1'b0;
        reset     = 1'b0;
        bus.in_a  = 32'd0;
        bus.in_b  = 32'd0;
        bus.inst  = 32'd0;

`ifdef EXEC_OUTREG_EN
        apply("reset_state", 1'b1, 32'd5, 32'd7, 32'h0000_0033, 32'd0, 1'b0, 32'd0);
`endif
        apply("sub",     1'b0, 32'd5, 32'd7, 32'h4000_0033, 32'hFFFF_FFFE, 1'b0, 32'd0);
        apply("add",     1'b0, 32'd5, 32'd7, 32'h0000_0033, 32'd12, 1'b0, 32'd0);
        apply("addi_b30",1'b0, 32'd5, 32'd7, 32'h4000_0013, 32'd12, 1'b0, 32'h0000_0400);
        apply("sra",     1'b0, 32'h8000_0000, 32'h24, 32'h4000_5033, 32'hF800_0000, 1'b0, 32'd0);
        apply("srl",     1'b0, 32'h8000_0000, 32'h24, 32'h0000_5033, 32'h0800_0000, 1'b0, 32'd0);
        apply("slt",     1'b0, 32'hFFFF_FFFF, 32'd1, 32'h0000_2033, 32'd1, 1'b0, 32'd0);
        apply("sltu",    1'b0, 32'hFFFF_FFFF, 32'd1, 32'h0000_3033, 32'd0, 1'b0, 32'd0);
        apply("blt",     1'b0, 32'hFFFF_FFFF, 32'd1, 32'h0000_4063, 32'd0, 1'b1, 32'd0);
        apply("bgeu",    1'b0, 32'hFFFF_FFFF, 32'd1, 32'h0000_7063, 32'd0, 1'b1, 32'd0);
        apply("beq_ne",  1'b0, 32'hFFFF_FFFF, 32'd1, 32'h0000_0063, 32'd0, 1'b0, 32'd0);
        apply("bne",     1'b0, 32'hFFFF_FFFF, 32'd1, 32'h0000_1063, 32'd0, 1'b1, 32'd0);
        apply("bge",     1'b0, 32'hFFFF_FFFF, 32'd1, 32'h0000_5063, 32'd0, 1'b0, 32'd0);
        apply("bltu",    1'b0, 32'hFFFF_FFFF, 32'd1, 32'h0000_6063, 32'd0, 1'b0, 32'd0);
        apply("br_f3_2", 1'b0, 32'hFFFF_FFFF, 32'd1, 32'h0000_2063, 32'd0, 1'b0, 32'd0);
        apply("add_eq",  1'b0, 32'd9, 32'd9, 32'h0000_0033, 32'd18, 1'b0, 32'd0);
        apply("xor",     1'b0, 32'hF0F0_F0F0, 32'h0FF0_0021, 32'h0000_4033, 32'hFF00_F0D1, 1'b0, 32'd0);
        apply("or",      1'b0, 32'hF0F0_F0F0, 32'h0FF0_0021, 32'h0000_6033, 32'hFFF0_F0F1, 1'b0, 32'd0);
        apply("and",     1'b0, 32'hF0F0_F0F0, 32'h0FF0_0021, 32'h0000_7033, 32'h00F0_0020, 1'b0, 32'd0);
        apply("sll",     1'b0, 32'hF0F0_F0F0, 32'h0FF0_0021, 32'h0000_1033, 32'hE1E1_E1E0, 1'b0, 32'd0);
        apply("addi_m1", 1'b0, 32'd0, 32'd0, 32'hFFF0_0093, 32'd0, 1'b0, 32'hFFFF_FFFF);
        apply("sb_m1",   1'b0, 32'h100, 32'hFFFF_FFFF, 32'hFE00_0FA3, 32'h0000_00FF, 1'b0, 32'hFFFF_FFFF);
        apply("jal",     1'b0, 32'h1000, 32'd4, 32'h8000_00EF, 32'h0000_1004, 1'b0, 32'hFFF0_0000);
        apply("lui",     1'b0, 32'd0, 32'h1234_5000, 32'h1234_50B7, 32'h1234_5000, 1'b0, 32'h1234_5000);
        apply("beq_m4",  1'b0, 32'd7, 32'd7, 32'hFE00_0EE3, 32'd14, 1'b1, 32'hFFFF_FFFC);
        apply("system",  1'b0, 32'd1, 32'd2, 32'h0010_0073, 32'd3, 1'b0, 32'd0);
        apply("auipc",   1'b0, 32'h2000, 32'hFFFF_F000, 32'hFFFF_F017, 32'h0000_1000, 1'b0, 32'hFFFF_F000);
        apply("op_imm0", 1'b0, 32'd1, 32'd1, 32'h0000_0033, 32'd2, 1'b0, 32'd0);
`ifdef EXEC_OUTREG_EN
        apply("reg_add", 1'b0, 32'd3, 32'd4, 32'h0000_0033, 32'd7, 1'b0, 32'd0);
        apply("reg_rst", 1'b1, 32'd7, 32'd7, 32'hFE00_0EE3, 32'd0, 1'b0, 32'd0);
        apply("post_rst",1'b0, 32'd3, 32'd4, 32'h0000_0033, 32'd7, 1'b0, 32'd0);
`endif

        @(negedge clk);
        vec_valid = 1'b0;
        reset     = 1'b0;
        repeat (3) @(negedge clk);

        n_checks++;
        if (exp_q.size() == 0) begin
            n_pass++;
        end else begin
            $display("FAIL drain: %0d expected entries left, expected 0", exp_q.size());
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
